// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART tx core between NUM_REQ
// byte requesters. Each grant moves one byte into the core through the
// send/din/busy handshake, and arbitration resumes only after the frame ends.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ           = 4,
    parameter int unsigned DATA_WIDTH        = 8,
    parameter int unsigned BUSY_TIMEOUT_CLKS = 16
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic [NUM_REQ-1:0]              i_req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   i_req_data,
    output logic [NUM_REQ-1:0]              o_req_ack,
    output logic [$clog2(NUM_REQ)-1:0]      o_grant_id,
    output logic                            o_arb_busy,
    output logic                            o_timeout_err,
    output logic                            o_tx_send,
    output logic [DATA_WIDTH-1:0]           o_tx_din,
    input  logic                            i_tx_busy
);

    localparam int unsigned GW = $clog2(NUM_REQ);
    localparam int unsigned TW = $clog2(BUSY_TIMEOUT_CLKS) + 1;
    localparam logic [GW-1:0] LAST_INIT = GW'(NUM_REQ - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(BUSY_TIMEOUT_CLKS - 1);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_DONE
    } state_t;

    state_t                  r_state;
    logic [NUM_REQ-1:0]      r_req_ack;
    logic [GW-1:0]           r_grant_id;
    logic [GW-1:0]           r_last_grant;
    logic                    r_timeout_err;
    logic                    r_tx_send;
    logic [DATA_WIDTH-1:0]   r_tx_din;
    logic [TW-1:0]           r_tmo_cnt;

    logic                    w_found;
    logic [GW-1:0]           w_win;
    logic [NUM_REQ-1:0]      w_win_onehot;
    logic [DATA_WIDTH-1:0]   w_win_data;
    int unsigned             w_idx;
    logic [GW-1:0]           w_idx_s;

    // Round-robin scan starting just after the last granted requester.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = 0;
        w_idx_s = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            w_idx   = (32'(r_last_grant) + k) % NUM_REQ;
            w_idx_s = w_idx[GW-1:0];
            if (!w_found && i_req_valid[w_idx_s]) begin
                w_found = 1'b1;
                w_win   = w_idx_s;
            end
        end
    end

    // Decode the winner into an ack mask and select its byte.
    always_comb begin
        w_win_onehot        = '0;
        w_win_onehot[w_win] = 1'b1;
        w_win_data          = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (GW'(i) == w_win) begin
                w_win_data = i_req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Arbitration FSM with all outputs registered.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= IDLE;
            r_req_ack     <= '0;
            r_grant_id    <= '0;
            r_last_grant  <= LAST_INIT;
            r_timeout_err <= 1'b0;
            r_tx_send     <= 1'b0;
            r_tx_din      <= '0;
            r_tmo_cnt     <= '0;
        end else begin
            r_req_ack <= '0;
            case (r_state)
                IDLE: begin
                    if (!i_tx_busy && w_found) begin
                        r_req_ack    <= w_win_onehot;
                        r_tx_din     <= w_win_data;
                        r_grant_id   <= w_win;
                        r_last_grant <= w_win;
                        r_tx_send    <= 1'b1;
                        r_tmo_cnt    <= '0;
                        r_state      <= SEND;
                    end
                end
                SEND: begin
                    r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    if (i_tx_busy) begin
                        r_tx_send <= 1'b0;
                        r_state   <= WAIT_DONE;
                    end else if (r_tmo_cnt == TMO_LAST) begin
                        // Byte is dropped; its requester was already acked.
                        r_tx_send     <= 1'b0;
                        r_timeout_err <= 1'b1;
                        r_state       <= IDLE;
                    end
                end
                WAIT_DONE: begin
                    if (!i_tx_busy) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_tx_send <= 1'b0;
                end
            endcase
        end
    end

    assign o_req_ack     = r_req_ack;
    assign o_grant_id    = r_grant_id;
    assign o_arb_busy    = (r_state != IDLE);
    assign o_timeout_err = r_timeout_err;
    assign o_tx_send     = r_tx_send;
    assign o_tx_din      = r_tx_din;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a behavioural tx core model.
module tb_uart_tx_arbiter;

    localparam int NREQ  = 4;
    localparam int DW    = 8;
    localparam int TMO   = 16;
    localparam int FRAME = 20;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*DW-1:0]   req_data;
    logic [NREQ-1:0]      req_ack;
    logic [1:0]           grant_id;
    logic                 arb_busy;
    logic                 timeout_err;
    logic                 tx_send;
    logic [DW-1:0]        tx_din;
    logic                 tx_busy;

    logic                 tv [NREQ];
    logic [DW-1:0]        td [NREQ];

    logic                 core_en;
    logic                 force_busy;
    logic                 core_busy;
    int                   core_cnt;
    logic                 cap_pulse;
    logic [DW-1:0]        cap_byte;

    typedef struct {
        int            id;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          ack_q [$];
    logic [DW-1:0] rx_q  [$];
    exp_t          mon_e;
    logic [DW-1:0] mon_b;

    int checks = 0;
    int errors = 0;

    uart_tx_arbiter #(
        .NUM_REQ           (NREQ),
        .DATA_WIDTH        (DW),
        .BUSY_TIMEOUT_CLKS (TMO)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_req_valid   (req_valid),
        .i_req_data    (req_data),
        .o_req_ack     (req_ack),
        .o_grant_id    (grant_id),
        .o_arb_busy    (arb_busy),
        .o_timeout_err (timeout_err),
        .o_tx_send     (tx_send),
        .o_tx_din      (tx_din),
        .i_tx_busy     (tx_busy)
    );

    always #5 clk = ~clk;

    // Pack per-requester drivers into the DUT vectors.
    always_comb begin
        req_valid = '0;
        req_data  = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]          = tv[i];
            req_data[i*DW +: DW]  = td[i];
        end
    end

    assign tx_busy = core_busy | force_busy;

    // Tx core model: latches din on send, then stays busy for FRAME clocks.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            core_busy <= 1'b0;
            core_cnt  <= 0;
            cap_pulse <= 1'b0;
            cap_byte  <= '0;
        end else begin
            cap_pulse <= 1'b0;
            if (core_busy) begin
                if (core_cnt == 1) core_busy <= 1'b0;
                core_cnt <= core_cnt - 1;
            end else if (core_en && tx_send) begin
                core_busy <= 1'b1;
                core_cnt  <= FRAME;
                cap_byte  <= tx_din;
                cap_pulse <= 1'b1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard monitor: acks and captured bytes against the expectation queues.
    always @(negedge clk) begin
        if (!rst && req_ack != '0) begin
            if (ack_q.size() == 0) begin
                check("ack_unexpected", 32'(req_ack), 32'd0);
            end else begin
                mon_e = ack_q.pop_front();
                check("ack_onehot", 32'(req_ack), 32'(1 << mon_e.id));
                check("grant_id", 32'(grant_id), 32'(mon_e.id));
                check("tx_din", 32'(tx_din), 32'(mon_e.data));
            end
        end
        if (!rst && cap_pulse) begin
            if (rx_q.size() == 0) begin
                check("rx_unexpected", 32'(cap_byte), 32'hFFFF);
            end else begin
                mon_b = rx_q.pop_front();
                check("rx_byte", 32'(cap_byte), 32'(mon_b));
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_byte(input int id, input logic [DW-1:0] d, input bit rx);
        exp_t e;
        e.id   = id;
        e.data = d;
        ack_q.push_back(e);
        if (rx) rx_q.push_back(d);
    endtask

    task automatic send_byte(input int id, input logic [DW-1:0] d);
        int n;
        tv[id] = 1'b1;
        td[id] = d;
        n = 0;
        do begin
            tick();
            n++;
        end while (!req_ack[id] && n < 2000);
        if (!req_ack[id]) check($sformatf("ack_wait_r%0d", id), 32'd0, 32'd1);
        tv[id] = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while ((arb_busy || tx_busy) && n < 1000) begin
            tick();
            n++;
        end
        check(tag, 32'(arb_busy | tx_busy), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int i = 0; i < NREQ; i++) begin
            tv[i] = 1'b0;
            td[i] = '0;
        end
        core_en    = 1'b1;
        force_busy = 1'b0;
        rst        = 1'b1;
        #3;
        check("rst_ack", 32'(req_ack), 32'd0);
        check("rst_grant", 32'(grant_id), 32'd0);
        check("rst_send", 32'(tx_send), 32'd0);
        check("rst_din", 32'(tx_din), 32'd0);
        check("rst_busy", 32'(arb_busy), 32'd0);
        check("rst_tmo", 32'(timeout_err), 32'd0);
        tick(2);
        rst = 1'b0;
        tick();

        // 1: single byte from requester 2
        do_reset();
        expect_byte(2, 8'hA5, 1'b1);
        send_byte(2, 8'hA5);
        wait_idle("t1_idle");
        check("t1_arb_busy", 32'(arb_busy), 32'd0);
        check("t1_grant_hold", 32'(grant_id), 32'd2);
        check("t1_din_hold", 32'(tx_din), 32'hA5);
        check("t1_rx_done", 32'(rx_q.size()), 32'd0);

        // 2: all four at once, order 0..3 after reset
        do_reset();
        for (int i = 0; i < NREQ; i++) expect_byte(i, 8'(8'h10 + 8'h11 * i), 1'b1);
        fork
            send_byte(0, 8'h10);
            send_byte(1, 8'h21);
            send_byte(2, 8'h32);
            send_byte(3, 8'h43);
        join
        wait_idle("t2_idle");
        check("t2_ackq", 32'(ack_q.size()), 32'd0);
        check("t2_rxq", 32'(rx_q.size()), 32'd0);

        // 3: req0 and req3 continuously valid -> 0,3,0,3,0,3
        for (int k = 0; k < 3; k++) begin
            expect_byte(0, 8'(8'h50 + k), 1'b1);
            expect_byte(3, 8'(8'h60 + k), 1'b1);
        end
        fork
            begin
                for (int k = 0; k < 3; k++) send_byte(0, 8'(8'h50 + k));
            end
            begin
                for (int k = 0; k < 3; k++) send_byte(3, 8'(8'h60 + k));
            end
        join
        wait_idle("t3_idle");
        check("t3_ackq", 32'(ack_q.size()), 32'd0);

        // 4: core never answers -> timeout after 16 clocks of tx_send
        core_en = 1'b0;
        expect_byte(1, 8'h7E, 1'b0);
        send_byte(1, 8'h7E);
        n = 0;
        while (tx_send && n < 40) begin
            n++;
            tick();
        end
        check("t4_send_clks", 32'(n), 32'(TMO));
        check("t4_tmo_err", 32'(timeout_err), 32'd1);
        check("t4_idle", 32'(arb_busy), 32'd0);
        expect_byte(2, 8'h3C, 1'b0);
        send_byte(2, 8'h3C);
        wait_idle("t4_idle2");
        check("t4_tmo_sticky", 32'(timeout_err), 32'd1);
        core_en = 1'b1;

        // 5: async reset during WAIT_DONE
        expect_byte(1, 8'h96, 1'b1);
        send_byte(1, 8'h96);
        n = 0;
        while (!(arb_busy && !tx_send && tx_busy) && n < 100) begin
            tick();
            n++;
        end
        check("t5_in_wait", 32'(arb_busy && !tx_send && tx_busy), 32'd1);
        tick(3);
        check("t5_tmo_pre", 32'(timeout_err), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("t5_send", 32'(tx_send), 32'd0);
        check("t5_ack", 32'(req_ack), 32'd0);
        check("t5_busy", 32'(arb_busy), 32'd0);
        check("t5_tmo", 32'(timeout_err), 32'd0);
        tick(2);
        rst = 1'b0;
        tick();
        expect_byte(0, 8'hA0, 1'b1);
        expect_byte(1, 8'hA1, 1'b1);
        fork
            send_byte(0, 8'hA0);
            send_byte(1, 8'hA1);
        join
        wait_idle("t5_idle");

        // 6: tx_busy held high in IDLE blocks the grant
        force_busy = 1'b1;
        expect_byte(2, 8'hC3, 1'b1);
        tv[2] = 1'b1;
        td[2] = 8'hC3;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("t6_no_ack", 32'(req_ack), 32'd0);
        end
        force_busy = 1'b0;
        tick();
        check("t6_ack_lat", 32'(req_ack), 32'b0100);
        tv[2] = 1'b0;
        wait_idle("t6_idle");

        check("end_ackq", 32'(ack_q.size()), 32'd0);
        check("end_rxq", 32'(rx_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
